// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared definitions for the branch recovery controller: FSM encoding and
// default sizing constants.
package branch_recovery_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_DEPTH        = 4;
  localparam int unsigned DEFAULT_FLUSH_CYCLES = 2;
  localparam int unsigned DEFAULT_AW           = 32;

  // Wide enough for FLUSH_CYCLES up to 15.
  localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_recovery_ctrl_pred_fifo.sv
// Prediction tracking FIFO: holds one {pred, altPC} record per in-flight
// branch. The caller only asserts push when there is room (or a pop happens
// in the same cycle) and only asserts pop when the FIFO is not empty.
// clear has priority over push and pop.
module pred_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next storage, pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Branch recovery controller: tracks predicted branches from ID, checks
// them at resolution in EX, trains the predictor, and on a mispredict
// redirects fetch and holds Flush for FLUSH_CYCLES cycles.
module branch_recovery_ctrl
  import branch_recovery_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  parameter int unsigned AW           = DEFAULT_AW
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          PredValid_ID,
  input  logic          Prediction_ID,
  input  logic [AW-1:0] Target_ID,
  input  logic [AW-1:0] FallThrough_ID,
  input  logic          Resolve_EX,
  input  logic          Taken_EX,
  input  logic          Stall,
  output logic          Flush,
  output logic          Redirect,
  output logic [AW-1:0] RedirectPC,
  output logic          UpdateValid,
  output logic          UpdateTaken,
  output logic          Full,
  output logic          Error,
  output logic [15:0]   MispredCount
);

  localparam int unsigned EW = AW + 1;
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LEN = FLUSH_CNT_W'(FLUSH_CYCLES);

  state_e                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   redirect_q, redirect_d;
  logic [AW-1:0]          redirect_pc_q, redirect_pc_d;
  logic                   update_valid_q, update_valid_d;
  logic                   update_taken_q, update_taken_d;
  logic                   error_q, error_d;
  logic [15:0]            mispred_count_q, mispred_count_d;

  logic          fifo_full, fifo_empty;
  logic [EW-1:0] fifo_din, fifo_dout;
  logic          head_pred;
  logic [AW-1:0] head_alt;

  logic active, push_req, pop_req, pop_ok, push_ok, mispred, err_now;

  assign fifo_din  = {Prediction_ID, (Prediction_ID ? FallThrough_ID : Target_ID)};
  assign head_pred = fifo_dout[AW];
  assign head_alt  = fifo_dout[AW-1:0];

  pred_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_pred_fifo (
    .clk   (Clock),
    .rst_n (Reset_n),
    .push  (push_ok),
    .pop   (pop_ok),
    .clear (mispred),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Qualify push/pop requests; a full FIFO still accepts a push when a pop
  // frees a slot in the same cycle, and a mispredict drops the push.
  always_comb begin
    active   = (state_q == ST_RUN) && !Stall;
    push_req = active && PredValid_ID;
    pop_req  = active && Resolve_EX;
    pop_ok   = pop_req && !fifo_empty;
    mispred  = pop_ok && (Taken_EX != head_pred);
    push_ok  = push_req && (!fifo_full || pop_ok) && !mispred;
    err_now  = (pop_req && fifo_empty) || (push_req && fifo_full && !pop_ok);
  end

  // FSM state register; the flush counter keeps running through Stall.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // FSM next state: FLUSH lasts FLUSH_LEN cycles including the Redirect cycle.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mispred) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LEN;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    Flush = (state_q == ST_FLUSH);
  end

  // Next values for the registered redirect, training and status outputs.
  always_comb begin
    redirect_d      = mispred;
    redirect_pc_d   = mispred ? head_alt : redirect_pc_q;
    update_valid_d  = pop_ok;
    update_taken_d  = pop_ok && Taken_EX;
    error_d         = error_q || err_now;
    mispred_count_d = mispred_count_q;
    if (mispred && (mispred_count_q != '1)) begin
      mispred_count_d = mispred_count_q + 16'd1;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      redirect_q      <= 1'b0;
      redirect_pc_q   <= '0;
      update_valid_q  <= 1'b0;
      update_taken_q  <= 1'b0;
      error_q         <= 1'b0;
      mispred_count_q <= '0;
    end else begin
      redirect_q      <= redirect_d;
      redirect_pc_q   <= redirect_pc_d;
      update_valid_q  <= update_valid_d;
      update_taken_q  <= update_taken_d;
      error_q         <= error_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign Redirect     = redirect_q;
  assign RedirectPC   = redirect_pc_q;
  assign UpdateValid  = update_valid_q;
  assign UpdateTaken  = update_taken_q;
  assign Error        = error_q;
  assign MispredCount = mispred_count_q;
  assign Full         = fifo_full;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl (DEPTH=4, FLUSH_CYCLES=2, AW=32).
module tb_branch_recovery_ctrl;

  typedef struct packed {
    logic        flush;
    logic        redir;
    logic [31:0] pc;
    logic        uv;
    logic        ut;
    logic        full;
    logic        err;
    logic [15:0] mc;
  } exp_t;

  typedef struct {
    string       nm;
    logic        pv;
    logic        pred;
    logic [31:0] tgt;
    logic [31:0] ft;
    logic        res;
    logic        tk;
    logic        st;
    exp_t        e;
  } vec_t;

  logic        Clock, Reset_n;
  logic        PredValid_ID, Prediction_ID, Resolve_EX, Taken_EX, Stall;
  logic [31:0] Target_ID, FallThrough_ID;
  logic        Flush, Redirect, UpdateValid, UpdateTaken, Full, Error;
  logic [31:0] RedirectPC;
  logic [15:0] MispredCount;

  int checks   = 0;
  int failures = 0;

  vec_t vq[$];

  branch_recovery_ctrl #(
    .DEPTH        (4),
    .FLUSH_CYCLES (2),
    .AW           (32)
  ) dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .PredValid_ID   (PredValid_ID),
    .Prediction_ID  (Prediction_ID),
    .Target_ID      (Target_ID),
    .FallThrough_ID (FallThrough_ID),
    .Resolve_EX     (Resolve_EX),
    .Taken_EX       (Taken_EX),
    .Stall          (Stall),
    .Flush          (Flush),
    .Redirect       (Redirect),
    .RedirectPC     (RedirectPC),
    .UpdateValid    (UpdateValid),
    .UpdateTaken    (UpdateTaken),
    .Full           (Full),
    .Error          (Error),
    .MispredCount   (MispredCount)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic exp_t ex(logic f, logic r, logic [31:0] pc, logic uv, logic ut,
                              logic fu, logic er, logic [15:0] mc);
    exp_t e;
    e.flush = f; e.redir = r; e.pc = pc; e.uv = uv; e.ut = ut;
    e.full = fu; e.err = er; e.mc = mc;
    return e;
  endfunction

  function automatic vec_t mk(string nm, logic pv, logic pred, logic [31:0] tgt,
                              logic [31:0] ft, logic res, logic tk, logic st, exp_t e);
    vec_t v;
    v.nm = nm; v.pv = pv; v.pred = pred; v.tgt = tgt; v.ft = ft;
    v.res = res; v.tk = tk; v.st = st; v.e = e;
    return v;
  endfunction

  task automatic check(input string nm, input exp_t e);
    exp_t a;
    a = '{flush: Flush, redir: Redirect, pc: RedirectPC, uv: UpdateValid,
          ut: UpdateTaken, full: Full, err: Error, mc: MispredCount};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got flush=%0b redir=%0b pc=%h uv=%0b ut=%0b full=%0b err=%0b mc=%0d ; want flush=%0b redir=%0b pc=%h uv=%0b ut=%0b full=%0b err=%0b mc=%0d",
               nm, a.flush, a.redir, a.pc, a.uv, a.ut, a.full, a.err, a.mc,
               e.flush, e.redir, e.pc, e.uv, e.ut, e.full, e.err, e.mc);
    end
  endtask

  task automatic idle_inputs();
    PredValid_ID = 0; Prediction_ID = 0; Target_ID = '0; FallThrough_ID = '0;
    Resolve_EX = 0; Taken_EX = 0; Stall = 0;
  endtask

  task automatic step(input vec_t v);
    PredValid_ID = v.pv; Prediction_ID = v.pred; Target_ID = v.tgt;
    FallThrough_ID = v.ft; Resolve_EX = v.res; Taken_EX = v.tk; Stall = v.st;
    @(posedge Clock);
    #1;
    check(v.nm, v.e);
  endtask

  task automatic do_reset(input string nm);
    idle_inputs();
    Reset_n = 0;
    repeat (2) @(posedge Clock);
    #1;
    check(nm, ex(0, 0, 0, 0, 0, 0, 0, 0));
    Reset_n = 1;
  endtask

  initial begin
    idle_inputs();
    Reset_n = 0;
    #1;

    // Correct prediction, mispredict with FLUSH-time ignore, fill/overflow,
    // stall freeze, simultaneous push+pop at full, ordered drain.
    vq.push_back(mk("a_push",  1, 1, 'h100, 'h44, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("a_res",   0, 0, 0, 0,        1, 1, 0, ex(0, 0, 0, 1, 1, 0, 0, 0)));
    vq.push_back(mk("a_idle",  0, 0, 0, 0,        0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("b_push",  1, 0, 'h200, 'h48, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("b_res",   0, 0, 0, 0,        1, 1, 0, ex(1, 1, 'h200, 1, 1, 0, 0, 1)));
    vq.push_back(mk("b_fl2",   1, 1, 'h999, 'h998, 1, 0, 0, ex(1, 0, 'h200, 0, 0, 0, 0, 1)));
    vq.push_back(mk("b_run",   0, 0, 0, 0,        0, 0, 0, ex(0, 0, 'h200, 0, 0, 0, 0, 1)));
    vq.push_back(mk("c_push0", 1, 1, 'h300, 'h310, 0, 0, 0, ex(0, 0, 'h200, 0, 0, 0, 0, 1)));
    vq.push_back(mk("c_push1", 1, 1, 'h301, 'h311, 0, 0, 0, ex(0, 0, 'h200, 0, 0, 0, 0, 1)));
    vq.push_back(mk("c_push2", 1, 1, 'h302, 'h312, 0, 0, 0, ex(0, 0, 'h200, 0, 0, 0, 0, 1)));
    vq.push_back(mk("c_push3", 1, 1, 'h303, 'h313, 0, 0, 0, ex(0, 0, 'h200, 0, 0, 1, 0, 1)));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("c_stall", 1, 0, 'h3ff, 'h3fe, 1, 1, 1, ex(0, 0, 'h200, 0, 0, 1, 0, 1)));
    vq.push_back(mk("c_over",  1, 1, 'h304, 'h314, 0, 0, 0, ex(0, 0, 'h200, 0, 0, 1, 1, 1)));
    vq.push_back(mk("c_pp",    1, 0, 'h3AA, 'h3AB, 1, 1, 0, ex(0, 0, 'h200, 1, 1, 1, 1, 1)));
    vq.push_back(mk("c_hold",  0, 0, 0, 0,         0, 0, 0, ex(0, 0, 'h200, 0, 0, 1, 1, 1)));
    vq.push_back(mk("c_pop1",  0, 0, 0, 0,         1, 1, 0, ex(0, 0, 'h200, 1, 1, 0, 1, 1)));
    vq.push_back(mk("c_pop2",  0, 0, 0, 0,         1, 1, 0, ex(0, 0, 'h200, 1, 1, 0, 1, 1)));
    vq.push_back(mk("c_pop3",  0, 0, 0, 0,         1, 1, 0, ex(0, 0, 'h200, 1, 1, 0, 1, 1)));
    vq.push_back(mk("c_pop4",  0, 0, 0, 0,         1, 1, 0, ex(1, 1, 'h3AA, 1, 1, 0, 1, 2)));
    vq.push_back(mk("c_fl2",   1, 1, 'h1, 'h2,     1, 1, 1, ex(1, 0, 'h3AA, 0, 0, 0, 1, 2)));
    vq.push_back(mk("c_run",   0, 0, 0, 0,         0, 0, 0, ex(0, 0, 'h3AA, 0, 0, 0, 1, 2)));

    do_reset("reset0");
    foreach (vq[i]) step(vq[i]);

    // Mispredict on the older of two entries drops the same-cycle push and
    // empties the queue; a later resolve then hits an empty queue.
    do_reset("reset_d");
    step(mk("d_push1", 1, 1, 'h600, 'h604, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
    step(mk("d_push2", 1, 0, 'h700, 'h704, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
    step(mk("d_misp",  1, 1, 'h800, 'h804, 1, 0, 0, ex(1, 1, 'h604, 1, 0, 0, 0, 1)));
    step(mk("d_fl2",   0, 0, 0, 0,         0, 0, 0, ex(1, 0, 'h604, 0, 0, 0, 0, 1)));
    step(mk("d_run",   0, 0, 0, 0,         0, 0, 0, ex(0, 0, 'h604, 0, 0, 0, 0, 1)));
    step(mk("d_empty", 0, 0, 0, 0,         1, 1, 0, ex(0, 0, 'h604, 0, 0, 0, 1, 1)));

    // Asynchronous reset in the second FLUSH cycle aborts the flush.
    do_reset("reset_e");
    step(mk("e_push",  1, 0, 'h900, 'h904, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
    step(mk("e_misp",  0, 0, 0, 0,         1, 1, 0, ex(1, 1, 'h900, 1, 1, 0, 0, 1)));
    step(mk("e_fl2",   0, 0, 0, 0,         0, 0, 0, ex(1, 0, 'h900, 0, 0, 0, 0, 1)));
    Reset_n = 0;
    #1;
    check("e_async_rst", ex(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge Clock);
    #1;
    Reset_n = 1;
    step(mk("e_push2", 1, 1, 'h100, 'h44, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));
    step(mk("e_res",   0, 0, 0, 0,        1, 1, 0, ex(0, 0, 0, 1, 1, 0, 0, 0)));
    step(mk("e_idle",  0, 0, 0, 0,        0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_recovery_ctrl.md
BRANCH_RECOVERY_CTRL -- requirements
Module: branch_recovery_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 4, max in-flight predicted branches (power of 2, >=2).
REQ-002 SHALL have parameter FLUSH_CYCLES, 2, cycles Flush is held after a mispredict (1..15).
REQ-003 SHALL have parameter AW, 32, PC width.
REQ-004 Clock  in  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 PredValid_ID  in  1  branch in ID has received a prediction this cycle.
REQ-007 Prediction_ID  in  1  predicted direction (1 = taken).
REQ-008 Target_ID  in  AW  branch target PC.
REQ-009 FallThrough_ID  in  AW  PC+4 of the branch.
REQ-010 Resolve_EX  in  1  oldest outstanding branch resolves in EX this cycle.
REQ-011 Taken_EX  in  1  actual direction of the resolving branch.
REQ-012 Stall  in  1  pipeline frozen; no push or pop.
REQ-013 Flush  out  1  squash IF/ID.
REQ-014 Redirect  out  1  one-cycle pulse: load RedirectPC into PC.
REQ-015 RedirectPC  out  AW  corrected fetch address.
REQ-016 UpdateValid  out  1  one-cycle strobe to the predictor's training port.
REQ-017 UpdateTaken  out  1  outcome to train with; valid with UpdateValid.
REQ-018 Full  out  1  combinational; tracking queue holds DEPTH entries (pipeline must stall ID).
REQ-019 Error  out  1  sticky protocol-violation flag.
REQ-020 MispredCount  out  16  saturating mispredict counter.

Function
REQ-021 SHALL keep a FIFO of DEPTH entries {pred, altPC}; altPC = Target_ID when Prediction_ID=0, else FallThrough_ID.
REQ-022 FSM states RUN and FLUSH; RUN is the reset state.
REQ-023 In RUN with Stall=0: PredValid_ID pushes; Resolve_EX pops the head; simultaneous push and pop SHALL both take effect (count unchanged).
REQ-024 Pop with Taken_EX == head.pred: no redirect; state stays RUN.
REQ-025 Pop with Taken_EX != head.pred: in the next cycle Redirect=1, RedirectPC=head.altPC, Flush=1; FIFO emptied; state -> FLUSH; same-cycle push discarded.
REQ-026 FLUSH: Flush=1 for FLUSH_CYCLES cycles total, counting the Redirect cycle; then RUN. PredValid_ID and Resolve_EX are ignored in FLUSH.
REQ-027 Every accepted pop SHALL produce UpdateValid=1, UpdateTaken=Taken_EX exactly one cycle later, mispredict or not.
REQ-028 Stall=1 SHALL freeze FIFO and queue state; the FLUSH counter SHALL continue to count.
REQ-029 Push while Full (with no simultaneous pop), or pop while empty: ignored, Error set to 1 until reset.
REQ-030 MispredCount SHALL increment once per mispredict and saturate at 16'hFFFF.
REQ-031 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-032 Reset_n=0 SHALL asynchronously clear the FIFO, count and pointers, set state=RUN, and zero Flush, Redirect, RedirectPC, UpdateValid, UpdateTaken, Error and MispredCount.
REQ-033 Reset asserted during FLUSH SHALL abort the flush immediately; the first cycle after release is RUN with an empty queue.

Structure
REQ-034 A shared package SHALL hold the state encoding (RUN=0, FLUSH=1) and default DEPTH/FLUSH_CYCLES constants.
REQ-035 FIFO storage and pointers SHALL be a sub-module pred_fifo with push, pop, clear, full and empty ports; the FSM, counters and outputs stay in the top module.

Verification
REQ-036 Push taken (Target=0x100, FT=0x44), resolve Taken=1 -> no Redirect; UpdateValid=1, UpdateTaken=1 one cycle later.
REQ-037 Push not-taken (Target=0x200), resolve Taken=1 -> next cycle Redirect=1, RedirectPC=0x200; Flush high 2 cycles; MispredCount=1; queue empty.
REQ-038 Push 4 with no resolve -> Full=1; 5th push -> ignored, Error=1; then simultaneous push and pop -> count stays 4.
REQ-039 Two queued, first mispredicts with a same-cycle push -> push dropped; after FLUSH, a resolve sets Error (queue empty).
REQ-040 Assert Reset_n low during the second FLUSH cycle -> all outputs 0 at once; after release, a push then a resolve behave as in REQ-036.
REQ-041 Stall=1 with PredValid_ID and Resolve_EX both high for 3 cycles -> count unchanged, no UpdateValid.
